// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its issue scoreboard.
package regfile_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  // Hard-wired zero register; it is never written and never reported busy.
  localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/decoder5x32.sv
// Address-to-one-hot decoder with enable; used for write-back and issue vectors.
module decoder5x32 #(
  parameter int unsigned AW = 5
) (
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mux32.sv
// 32-to-1 read multiplexer selecting one register word by address.
module regfile_mux32 #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic [2**AW-1:0][DW-1:0] data,
  input  logic [AW-1:0]            sel,
  output logic [DW-1:0]            q
);

  always_comb begin
    q = data[sel];
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DW = regfile_pkg::DW,
  parameter int unsigned AW = regfile_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     rw,
  input  logic [DW-1:0]     pw,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  output logic [DW-1:0]     pa,
  output logic [DW-1:0]     pb,
  input  logic              iss,
  input  logic [AW-1:0]     rd_iss,
  output logic [2**AW-1:0]  busy,
  output logic              hazard
);

  localparam int unsigned NR = 2**AW;
  localparam logic [AW-1:0]  ZERO_IDX = AW'(ZERO_REG);
  // Every register except the zero register may be written or marked busy.
  localparam logic [NR-1:0]  NZ_MASK  = ~(NR'(1) << ZERO_IDX);

  logic [NR-1:0]         wr_dec;
  logic [NR-1:0]         iss_dec;
  logic [NR-1:0]         wr_en;
  logic [NR-1:0]         busy_set;
  logic [NR-1:0]         busy_clr;
  logic [NR-1:0]         busy_d;
  logic [NR-1:0]         busy_q;
  logic [NR-1:0][DW-1:0] regs_q;
  logic [DW-1:0]         rd_a;
  logic [DW-1:0]         rd_b;
  logic                  fwd_a;
  logic                  fwd_b;
  logic                  haz_a;
  logic                  haz_b;

  decoder5x32 #(
    .AW (AW)
  ) u_wr_dec (
    .en     (we),
    .addr   (rw),
    .onehot (wr_dec)
  );

  decoder5x32 #(
    .AW (AW)
  ) u_iss_dec (
    .en     (iss),
    .addr   (rd_iss),
    .onehot (iss_dec)
  );

  always_comb begin
    wr_en    = wr_dec & NZ_MASK;
    busy_set = iss_dec & NZ_MASK;
    busy_clr = wr_dec;
    // A newer issue to the same register outranks the completing write-back.
    busy_d   = ((busy_q & ~busy_clr) | busy_set) & NZ_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      for (int n = 0; n < int'(NR); n++) begin
        if (wr_en[n]) begin
          regs_q[n] <= pw;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  regfile_mux32 #(
    .DW (DW),
    .AW (AW)
  ) u_mux_a (
    .data (regs_q),
    .sel  (ra),
    .q    (rd_a)
  );

  regfile_mux32 #(
    .DW (DW),
    .AW (AW)
  ) u_mux_b (
    .data (regs_q),
    .sel  (rb),
    .q    (rd_b)
  );

`ifdef REGFILE_BYPASS_EN
  // Forwarding is held off during reset so the read ports stay at zero.
  assign fwd_a = we & ~rst & (rw == ra) & (ra != ZERO_IDX);
  assign fwd_b = we & ~rst & (rw == rb) & (rb != ZERO_IDX);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    pa     = fwd_a ? pw : rd_a;
    pb     = fwd_b ? pw : rd_b;
    haz_a  = (ra != ZERO_IDX) & busy_q[ra] & ~fwd_a;
    haz_b  = (rb != ZERO_IDX) & busy_q[rb] & ~fwd_b;
    hazard = haz_a | haz_b;
    busy   = busy_q;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the register data width in bits.
REQ-002 The block SHALL have parameter AW, default 5, meaning the register address width, giving 2**AW = 32 registers.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port we  input  1  meaning write-back enable.
REQ-006 The block SHALL have port rw  input  AW  meaning the write-back register address.
REQ-007 The block SHALL have port pw  input  DW  meaning the write-back data.
REQ-008 The block SHALL have ports ra and rb  input  AW  meaning the read-port A and read-port B source addresses.
REQ-009 The block SHALL have ports pa and pb  output  DW  meaning the read-port A and read-port B data.
REQ-010 The block SHALL have port iss  input  1  meaning an instruction with a destination is issuing this cycle.
REQ-011 The block SHALL have port rd_iss  input  AW  meaning the destination register of the issuing instruction.
REQ-012 The block SHALL have port busy  output  2**AW  meaning the scoreboard vector, where bit n set means a write to register n is pending.
REQ-013 The block SHALL have port hazard  output  1  meaning a source of the instruction currently in decode is pending.

Function
REQ-014 Register n (n != 0) SHALL load pw on the rising clk edge when we=1 and rw=n, and SHALL hold otherwise.
REQ-015 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-016 Reads SHALL be combinational: pa = R[ra] and pb = R[rb], with zero cycles of latency.
REQ-017 A busy bit n (n != 0) SHALL be set on the clk edge when iss=1 and rd_iss=n.
REQ-018 A busy bit n SHALL be cleared on the clk edge when we=1 and rw=n.
REQ-019 When a set and a clear hit the same bit in the same cycle, the set SHALL win, because the newer issue supersedes the completing write.
REQ-020 busy[0] SHALL be constant 0, and iss with rd_iss=0 SHALL have no effect.
REQ-021 Setting an already-set bit SHALL leave it set, and clearing an already-clear bit SHALL leave it clear; the block SHALL keep no per-register count.
REQ-022 hazard SHALL be combinational: (ra!=0 & busy[ra]) | (rb!=0 & busy[rb]), subject to REQ-026.
REQ-023 Simultaneous issue and write-back to different registers SHALL both take effect in the same cycle.

Reset
REQ-024 While rst=1, all registers SHALL be 0 and busy SHALL be all-zero, asynchronously; as a result pa, pb and hazard SHALL all be 0.
REQ-025 An assertion of rst in the middle of operation SHALL discard pending writes and busy bits, and a write or issue in the cycle rst deasserts SHALL be ignored only if rst is still high at that edge.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, the following SHALL apply:
- When we=1, rw=ra and ra!=0, pa SHALL equal pw in the same cycle; port B SHALL behave likewise.
- The hazard term for a source forwarded this way SHALL be suppressed.
REQ-027 With REGFILE_BYPASS_EN undefined, pa and pb SHALL show the old value until the edge after the write, and hazard SHALL remain asserted through the write-back cycle.

Structure
REQ-028 The constants NREG=32, DW and AW, and the zero-register index, SHALL reside in the shared package regfile_pkg.
REQ-029 The 5-to-32 one-hot write-enable decode SHALL be sub-module decoder5x32, which is reused for the busy-set and busy-clear vectors.
REQ-030 The read selection SHALL be the codebase's existing 32-to-1 read multiplexer, one instance per read port.

Verification
REQ-031 After reset, the bench SHALL set ra=5 and rb=31 and check pa=0, pb=0, busy=0 and hazard=0.
REQ-032 The bench SHALL write we=1, rw=3, pw=32'hDEADBEEF, set ra=3 on the next cycle, and check pa=32'hDEADBEEF; it SHALL then write rw=0, pw=32'hFFFFFFFF and check that ra=0 gives pa=0.
REQ-033 The bench SHALL issue iss=1, rd_iss=7 and then set ra=7, and check busy[7]=1 and hazard=1; it SHALL then write back we=1, rw=7, and check busy[7]=0 after the edge and hazard=0.
REQ-034 In the same cycle the bench SHALL drive iss=1, rd_iss=9, we=1, rw=9, and check busy[9]=1 afterwards.
REQ-035 With REGFILE_BYPASS_EN defined, the bench SHALL drive busy[4]=1, ra=4, we=1, rw=4, pw=32'h12345678 in one cycle, and check pa=32'h12345678 and hazard=0 in that cycle.
REQ-036 With REGFILE_BYPASS_EN undefined, the same stimulus as REQ-035 SHALL give the old value on pa and hazard=1 in that cycle.
REQ-037 The bench SHALL assert rst asynchronously mid-cycle with busy=32'h0000_0F00, and check that busy=0 and all registers=0 immediately, without waiting for a clk edge.
